// File: rtl/sad_pkg.sv
// Shared definitions for the SAD sequencer: FSM state encoding and default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   S_IDLE/S_RUN/S_DRAIN/S_DONE : 2-bit state encodings
//   state_t                     : enum built on those encodings
//   DEF_DATA_W / DEF_N_PAIRS    : default operand width and pairs per block
package sad_pkg;

  // Default widths.
  // The operand width is tied to the 4-bit abs_dif datapath.
  localparam int DEF_DATA_W  = 4;
  localparam int DEF_N_PAIRS = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_RUN   = S_RUN,
    ST_DRAIN = S_DRAIN,
    ST_DONE  = S_DONE
  } state_t;

endpackage

// File: rtl/abs_dif.sv
// Purpose: 4-bit unsigned absolute difference |aIn - bIn|.
// Latency: combinational, 0 cycles.
// Backpressure: none; this is a pure function of its inputs.
//
// Ports:
//   aIn [3:0] : operand A
//   bIn [3:0] : operand B
//   out [3:0] : |aIn - bIn|
module abs_dif (
  input  logic [3:0] aIn,
  input  logic [3:0] bIn,
  output logic [3:0] out
);

  assign out = (aIn >= bIn) ? (aIn - bIn) : (bIn - aIn);

endmodule

// File: rtl/sad_seq_ctrl.sv
// Purpose: stream N_PAIRS operand pairs through abs_dif and accumulate a block SAD.
// Latency: done pulses 2 cycles after the last accepted pair; the minimum block time is N_PAIRS+2 cycles.
// Backpressure: in_ready is high only in RUN; gaps in in_valid stall the pair count without losing pairs.
//
// Ports:
//   clk, rst           : clock and asynchronous active-high reset
//   start, abort       : begin a block (IDLE only) / cancel the current block
//   in_valid, in_ready : operand handshake; a pair transfers when both are high
//   a_in, b_in         : operand pair
//   busy, done         : busy is high outside IDLE; done is a 1-cycle pulse when sad_out updates
//   sad_out            : SAD of the last completed block
module sad_seq_ctrl
  import sad_pkg::*;
#(
  // Only 4 is supported, because the abs_dif datapath is 4 bits wide.
  parameter int DATA_W  = DEF_DATA_W,
  parameter int N_PAIRS = DEF_N_PAIRS,
  // One extra guard bit above DATA_W + log2(N_PAIRS) prevents overflow.
  parameter int ACC_W   = DATA_W + $clog2(N_PAIRS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  sad_out
);

  localparam int              CNT_W    = $clog2(N_PAIRS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PAIRS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dif_q, dif_d;
  logic              dif_v_q, dif_v_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  sad_q, sad_d;
  logic [DATA_W-1:0] dif_w;
  logic [ACC_W-1:0]  acc_sum;

  abs_dif u_abs_dif (
    .aIn (a_in),
    .bIn (b_in),
    .out (dif_w)
  );

  // The pipelined difference is folded in on every cycle it is valid, whatever the state.
  // The last pair is therefore added during DRAIN.
  assign acc_sum = dif_v_q ? (acc_q + ACC_W'(dif_q)) : acc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dif_d   = dif_q;
    dif_v_d = 1'b0;
    acc_d   = acc_sum;
    sad_d   = sad_q;

    case (state_q)
      ST_IDLE: begin
        // When start and abort are both high, abort takes priority.
        if (start && !abort) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end

      ST_RUN: begin
        if (abort) begin
          // A pair offered in this cycle is dropped.
          state_d = ST_IDLE;
        end else if (in_valid) begin
          dif_d   = dif_w;
          dif_v_d = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DRAIN;
            cnt_d   = '0;
          end
        end
      end

      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          // Capture the final sum on entry to DONE.
          // This makes sad_out valid during the same cycle that done is high.
          state_d = ST_DONE;
          sad_d   = acc_sum;
        end
      end

      ST_DONE: begin
        // Neither start nor abort has any effect here.
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dif_q   <= '0;
      dif_v_q <= 1'b0;
      acc_q   <= '0;
      sad_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dif_q   <= dif_d;
      dif_v_q <= dif_v_d;
      acc_q   <= acc_d;
      sad_q   <= sad_d;
    end
  end

  assign in_ready = (state_q == ST_RUN);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign sad_out  = sad_q;

endmodule

// File: tb/tb_sad_seq_ctrl.sv
// Testbench for sad_seq_ctrl, using one N_PAIRS=4 instance (index 0) and one N_PAIRS=8 instance (index 1).
// Inputs are driven on the falling clock edge.
// All outputs depend only on state, so they are sampled on that same falling edge.
module tb_sad_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start [2];
  logic       abort [2];
  logic       vld   [2];
  logic [3:0] a     [2];
  logic [3:0] b     [2];
  logic       rdy   [2];
  logic       busy  [2];
  logic       done  [2];
  logic [6:0] sad4;
  logic [7:0] sad8;
  logic [7:0] sad   [2];

  assign sad[0] = {1'b0, sad4};
  assign sad[1] = sad8;

  always #5 clk = ~clk;

  sad_seq_ctrl #(.DATA_W(4), .N_PAIRS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
    .in_valid(vld[0]), .in_ready(rdy[0]), .a_in(a[0]), .b_in(b[0]),
    .busy(busy[0]), .done(done[0]), .sad_out(sad4)
  );

  sad_seq_ctrl #(.DATA_W(4), .N_PAIRS(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
    .in_valid(vld[1]), .in_ready(rdy[1]), .a_in(a[1]), .b_in(b[1]),
    .busy(busy[1]), .done(done[1]), .sad_out(sad8)
  );

  int tests = 0;
  int fails = 0;
  int dcnt [2] = '{0, 0};

  // Reference model state: the SAD of the last completed block for each instance.
  int last_sad [2] = '{0, 0};

  // Count every done pulse, including any that appear when no completion is expected.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++)
      if (done[s] === 1'b1) dcnt[s]++;
  end

  task automatic check_b(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_v(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int absd(input int x, input int y);
    return (x > y) ? (x - y) : (y - x);
  endfunction

  // A block record.
  // Operand i is held in nibble i of a and b.
  // exp_sad is a hand-derived constant, or -1 to use the model sum.
  typedef struct {
    int          s;
    int          n;
    logic [31:0] a;
    logic [31:0] b;
    int          gap;
    int          exp_sad;
  } vec_t;

  // Run one block.
  // abort_at : pair index at which abort is raised (-1 for none).
  // start_at : pair index at which a stray start is pulsed (-1 for none).
  // poke     : raise start and abort during the DONE cycle.
  task automatic run_block(input vec_t v, input int abort_at, input int start_at,
                           input bit poke, input string tag);
    int s;
    int sum;
    int d0;
    int expv;
    int g;
    s   = v.s;
    sum = 0;
    d0  = dcnt[s];
    @(negedge clk);
    start[s] = 1'b1;
    @(negedge clk);
    start[s] = 1'b0;
    check_b({tag, "/run_rdy"}, rdy[s], 1'b1);
    for (int i = 0; i < v.n; i++) begin
      g = (v.gap > 0 && i > 0) ? $urandom_range(v.gap, 1) : 0;
      for (int k = 0; k < g; k++) begin
        vld[s] = 1'b0;
        @(negedge clk);
      end
      vld[s]   = 1'b1;
      a[s]     = v.a[4*i +: 4];
      b[s]     = v.b[4*i +: 4];
      start[s] = (i == start_at);
      abort[s] = (i == abort_at);
      if (!rdy[s]) check_b({tag, "/xfer_rdy"}, rdy[s], 1'b1);
      if (i == abort_at) begin
        @(negedge clk);
        abort[s] = 1'b0;
        vld[s]   = 1'b0;
        check_b({tag, "/abort_busy"}, busy[s], 1'b0);
        check_b({tag, "/abort_rdy"}, rdy[s], 1'b0);
        repeat (3) @(negedge clk);
        check_v({tag, "/abort_nodone"}, dcnt[s], d0);
        check_v({tag, "/abort_sad"}, 32'(sad[s]), last_sad[s]);
        return;
      end
      sum += absd(int'(v.a[4*i +: 4]), int'(v.b[4*i +: 4]));
      @(negedge clk);
    end
    vld[s]   = 1'b0;
    start[s] = 1'b0;
    expv = (v.exp_sad >= 0) ? v.exp_sad : sum;
    // One cycle after the last transfer: DRAIN.
    check_b({tag, "/drain_done"}, done[s], 1'b0);
    check_b({tag, "/drain_rdy"}, rdy[s], 1'b0);
    @(negedge clk);
    // Two cycles after the last transfer: DONE.
    check_b({tag, "/done"}, done[s], 1'b1);
    check_v({tag, "/sad"}, 32'(sad[s]), expv);
    if (poke) begin
      start[s] = 1'b1;
      abort[s] = 1'b1;
    end
    @(negedge clk);
    start[s] = 1'b0;
    abort[s] = 1'b0;
    check_b({tag, "/idle_busy"}, busy[s], 1'b0);
    check_b({tag, "/idle_done"}, done[s], 1'b0);
    check_v({tag, "/done_once"}, dcnt[s] - d0, 1);
    check_v({tag, "/sad_hold"}, 32'(sad[s]), expv);
    last_sad[s] = expv;
  endtask

  vec_t tbl [6];
  vec_t rv;

  initial begin
    // {s, n, a nibbles, b nibbles, gap, expected SAD}
    tbl[0] = '{0, 4, 32'h0000_C5A3, 32'h0000_054C, 0, 27};   // basic block
    tbl[1] = '{1, 8, 32'hFFFF_FFFF, 32'h0000_0000, 0, 120};  // maximum value
    tbl[2] = '{1, 8, 32'h7777_7777, 32'h7777_7777, 0, 0};    // all-equal pairs
    tbl[3] = '{0, 4, 32'h0000_C5A3, 32'h0000_054C, 3, 27};   // backpressure gaps
    tbl[4] = '{0, 4, 32'h0000_1111, 32'h0000_0000, 0, 4};    // (1,0) x4
    tbl[5] = '{1, 8, 32'h1234_5678, 32'h8765_4321, 2, 32};   // mixed, gaps

    for (int s = 0; s < 2; s++) begin
      start[s] = 1'b0; abort[s] = 1'b0; vld[s] = 1'b0; a[s] = '0; b[s] = '0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check_b($sformatf("reset%0d/rdy", s), rdy[s], 1'b0);
      check_b($sformatf("reset%0d/busy", s), busy[s], 1'b0);
      check_b($sformatf("reset%0d/done", s), done[s], 1'b0);
      check_v($sformatf("reset%0d/sad", s), 32'(sad[s]), 0);
    end
    rst = 1'b0;

    for (int t = 0; t < 6; t++)
      run_block(tbl[t], -1, -1, 1'b0, $sformatf("tbl%0d", t));

    // A start pulse while busy is ignored, and the block still completes.
    run_block(tbl[0], -1, 2, 1'b0, "start_busy");

    // in_valid held high in IDLE: nothing is accepted.
    vld[0] = 1'b1; a[0] = 4'd15; b[0] = 4'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_b($sformatf("idle_vld/rdy%0d", k), rdy[0], 1'b0);
    end
    vld[0] = 1'b0;
    check_b("idle_vld/busy", busy[0], 1'b0);
    check_v("idle_vld/sad", 32'(sad[0]), 27);

    // start and abort together in IDLE: abort wins.
    start[0] = 1'b1; abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; abort[0] = 1'b0;
    check_b("start_abort_idle/busy", busy[0], 1'b0);

    // Abort after 2 of 4 pairs; the previous SAD of 27 is kept.
    run_block(tbl[0], 2, -1, 1'b0, "abort");
    check_v("abort/keep27", 32'(sad[0]), 27);
    run_block(tbl[4], -1, -1, 1'b0, "after_abort");

    // start and abort raised during DONE: done still fires, and no restart follows.
    run_block(tbl[0], -1, -1, 1'b1, "done_poke");

    // Asynchronous reset asserted mid-RUN, between clock edges.
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vld[0] = 1'b1; a[0] = 4'd9; b[0] = 4'd1;
      @(negedge clk);
    end
    vld[0] = 1'b0;
    check_b("arst/pre_busy", busy[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    check_b("arst/busy", busy[0], 1'b0);
    check_b("arst/rdy", rdy[0], 1'b0);
    check_b("arst/done", done[0], 1'b0);
    check_v("arst/sad0", 32'(sad[0]), 0);
    check_v("arst/sad1", 32'(sad[1]), 0);
    last_sad[0] = 0;
    last_sad[1] = 0;
    @(negedge clk);
    rst = 1'b0;
    run_block(tbl[0], -1, -1, 1'b0, "after_arst");

    // Random blocks checked against the model sum, with occasional aborts.
    for (int t = 0; t < 16; t++) begin
      int ab;
      rv.s       = $urandom_range(1, 0);
      rv.n       = (rv.s == 1) ? 8 : 4;
      rv.a       = $urandom;
      rv.b       = $urandom;
      rv.gap     = $urandom_range(3, 0);
      rv.exp_sad = -1;
      ab = ($urandom_range(4, 0) == 0) ? $urandom_range(rv.n - 1, 0) : -1;
      run_block(rv, ab, -1, 1'b0, $sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
